// File: rtl/bk_mem_arbiter_if.sv
// Bundles the CPU bus, video fetch and SRAM pin groups of the BK memory arbiter.
// No logic and no latency; it only carries signals.
// Flow control: CPU level strobes with cpu_rdy, video level request with a vid_ack pulse.
`timescale 1ns/1ps
interface bk_mem_arbiter_if #(
    parameter int ADDR_W = 14
);
    // CPU bus port
    logic              cpu_rd;
    logic              cpu_wt;
    logic              cpu_byte;
    logic [15:0]       cpu_adr;
    logic [15:0]       cpu_out;
    logic [15:0]       cpu_in;
    logic              cpu_rdy;
    // Video scan-out fetcher
    logic              vid_req;
    logic [ADDR_W-1:0] vid_adr;
    logic              vid_ack;
    logic [15:0]       vid_data;
    // External SRAM pins
    logic [ADDR_W-1:0] sram_a;
    logic [15:0]       sram_d_i;
    logic [15:0]       sram_d_o;
    logic              sram_d_oe;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    // Arbiter side
    modport slave (
        input  cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_out,
        output cpu_in, cpu_rdy,
        input  vid_req, vid_adr,
        output vid_ack, vid_data,
        output sram_a, sram_d_o, sram_d_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
        input  sram_d_i
    );

    // Requester / memory side
    modport master (
        output cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_out,
        input  cpu_in, cpu_rdy,
        output vid_req, vid_adr,
        input  vid_ack, vid_data,
        input  sram_a, sram_d_o, sram_d_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
        output sram_d_i
    );
endinterface

// File: rtl/bk_mem_arbiter.sv
// Shares one 16-bit SRAM between the BK CPU port and the video fetcher, video first with CPU/video alternation.
// Latency: grant 1 clock after the request is seen in IDLE; cpu_rdy / vid_ack registered WAIT_STATES+1 clocks after grant.
// Backpressure: CPU stalls on its level strobes until cpu_rdy; video holds vid_req until vid_ack. Optional MEM_ARB_STATS_EN adds cpu_stall_cnt.
`timescale 1ns/1ps
module bk_mem_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 14
) (
    input  logic        m_clock,
    input  logic        p_reset,
    bk_mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] cpu_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        CPU_HOLD = 2'd2
    } state_t;

    localparam int WC_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_STATES);

    state_t            state;
    state_t            state_nxt;
    logic [WC_W-1:0]   wait_cnt;
    logic              last_vid;   // last grant went to video; CPU wins the next tie
    logic              cur_vid;    // access in progress belongs to video
    logic              cur_wr;     // access in progress is a write
    logic              cur_ub_n;
    logic              cur_lb_n;
    logic              wr_hold;    // first clock after a write ACCESS, keeps data on the bus with zero wait states
    logic              cpu_pend;
    logic              grant_vid;
    logic              grant_cpu;
    logic              acc_last;
    logic              unused_cpu_adr;

    // Address bits above the RAM window are decoded outside this block.
    assign unused_cpu_adr = ^bus.cpu_adr[15:ADDR_W+1];

    assign cpu_pend = (bus.cpu_rd | bus.cpu_wt) & ~bus.cpu_rdy;
    assign acc_last = (wait_cnt == WC_LAST);

    // IDLE arbitration: video first unless it had the previous grant and the CPU is waiting
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (state == IDLE) begin
            if (bus.vid_req && cpu_pend) begin
                if (last_vid) grant_cpu = 1'b1;
                else          grant_vid = 1'b1;
            end else if (bus.vid_req) begin
                grant_vid = 1'b1;
            end else if (cpu_pend) begin
                grant_cpu = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_vid || grant_cpu) state_nxt = ACCESS;
            ACCESS:   if (acc_last) state_nxt = cur_vid ? IDLE : CPU_HOLD;
            CPU_HOLD: if (!bus.cpu_rd && !bus.cpu_wt) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grant latching, access timing and registered completion strobes
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            wait_cnt     <= '0;
            last_vid     <= 1'b0;
            cur_vid      <= 1'b0;
            cur_wr       <= 1'b0;
            cur_ub_n     <= 1'b1;
            cur_lb_n     <= 1'b1;
            wr_hold      <= 1'b0;
            bus.sram_a   <= '0;
            bus.sram_d_o <= '0;
            bus.cpu_in   <= '0;
            bus.vid_data <= '0;
            bus.cpu_rdy  <= 1'b0;
            bus.vid_ack  <= 1'b0;
        end else begin
            bus.vid_ack <= 1'b0;
            wr_hold     <= (state == ACCESS) && acc_last && cur_wr;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_vid) begin
                        last_vid   <= 1'b1;
                        cur_vid    <= 1'b1;
                        cur_wr     <= 1'b0;
                        cur_ub_n   <= 1'b0;
                        cur_lb_n   <= 1'b0;
                        bus.sram_a <= bus.vid_adr;
                    end else if (grant_cpu) begin
                        last_vid     <= 1'b0;
                        cur_vid      <= 1'b0;
                        cur_wr       <= bus.cpu_wt;    // rd+wt together is a write
                        bus.sram_a   <= bus.cpu_adr[ADDR_W:1];
                        bus.sram_d_o <= bus.cpu_out;
                        if (bus.cpu_wt && bus.cpu_byte) begin
                            cur_ub_n <= ~bus.cpu_adr[0];
                            cur_lb_n <=  bus.cpu_adr[0];
                        end else begin
                            cur_ub_n <= 1'b0;
                            cur_lb_n <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_last) begin
                        if (cur_vid) begin
                            bus.vid_data <= bus.sram_d_i;
                            bus.vid_ack  <= 1'b1;
                        end else begin
                            if (!cur_wr) bus.cpu_in <= bus.sram_d_i;
                            bus.cpu_rdy <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CPU_HOLD: begin
                    if (!bus.cpu_rd && !bus.cpu_wt) bus.cpu_rdy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // SRAM strobes decoded from state so reset releases them asynchronously
    always_comb begin
        bus.sram_we_n = 1'b1;
        bus.sram_oe_n = 1'b1;
        bus.sram_ub_n = 1'b1;
        bus.sram_lb_n = 1'b1;
        bus.sram_d_oe = 1'b0;
        if (state == ACCESS) begin
            bus.sram_ub_n = cur_ub_n;
            bus.sram_lb_n = cur_lb_n;
            if (cur_wr) begin
                bus.sram_d_oe = 1'b1;
                // WE rises one clock before ACCESS ends so data is held past it
                if (WAIT_STATES == 0 || !acc_last) bus.sram_we_n = 1'b0;
            end else begin
                bus.sram_oe_n = 1'b0;
            end
        end else if (WAIT_STATES == 0 && wr_hold) begin
            bus.sram_d_oe = 1'b1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic        stall_evt;

    assign stall_evt     = (grant_vid && cpu_pend) || (state == ACCESS && cur_vid && cpu_pend);
    assign cpu_stall_cnt = stall_cnt;

    // Saturating count of clocks the CPU loses to video
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset)                             stall_cnt <= '0;
        else if (stall_evt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bk_mem_arbiter.sv
`timescale 1ns/1ps
module tb_bk_mem_arbiter;
    localparam int WS      = 1;
    localparam int AW      = 14;
    localparam int ACC_LAT = WS + 2;           // request edge + WS+1 access clocks
    localparam int MAX_LAT = 2 * (WS + 1) + 2;

    logic m_clock = 1'b0;
    logic p_reset;
    always #5 m_clock = ~m_clock;

    bk_mem_arbiter_if #(.ADDR_W(AW)) bus ();
`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_stall_cnt;
`endif

    bk_mem_arbiter #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .cpu_stall_cnt (cpu_stall_cnt)
`endif
    );

    // SRAM model and the bench's reference contents
    logic [15:0] sram    [0:(1<<AW)-1];
    logic [15:0] ref_mem [0:(1<<AW)-1];

    assign bus.sram_d_i = bus.sram_oe_n ? 16'h0000 : sram[bus.sram_a];

    always @(posedge m_clock) begin
        if (!bus.sram_we_n && bus.sram_d_oe) begin
            if (!bus.sram_ub_n) sram[bus.sram_a][15:8] = bus.sram_d_o[15:8];
            if (!bus.sram_lb_n) sram[bus.sram_a][7:0]  = bus.sram_d_o[7:0];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int stall_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic        is_rd;
        logic [15:0] data;
    } cpu_exp_t;

    cpu_exp_t    cpu_q[$];
    int          order[$];     // 1 = video completion, 0 = CPU completion
    logic [15:0] vid_exp;
    logic        rdy_prev;

    always @(negedge m_clock) begin
        if (p_reset) begin
            rdy_prev = 1'b0;
        end else begin
            if (bus.vid_ack) begin
                check("vid_data", bus.vid_data, vid_exp);
                order.push_back(1);
            end
            if (bus.cpu_rdy && !rdy_prev) begin
                n_tests++;
                if (cpu_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cpu_unexpected_rdy: got rdy with empty scoreboard");
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    if (e.is_rd && bus.cpu_in !== e.data) begin
                        n_fail++;
                        $display("FAIL cpu_rd_data: got %0h expected %0h", bus.cpu_in, e.data);
                    end
                end
                order.push_back(0);
            end
            rdy_prev = bus.cpu_rdy;
        end
    end

    // One CPU access: drive strobes, observe SRAM pins until cpu_rdy, then drop strobes.
    task automatic cpu_access(input logic rd, input logic wr, input logic bt,
                              input logic [15:0] adr, input logic [15:0] wdat,
                              output int lat, output int we_cnt, output int doe_cnt, output int oe_cnt,
                              output logic [AW-1:0] a_seen, output logic ub_seen, output logic lb_seen,
                              output logic hold_quiet, output logic rdy_after);
        cpu_exp_t e;
        logic [AW-1:0] w;
        w = adr[AW:1];
        e.is_rd = rd & ~wr;
        e.data  = ref_mem[w];
        if (wr) begin
            if (bt) begin
                if (adr[0]) ref_mem[w][15:8] = wdat[15:8];
                else        ref_mem[w][7:0]  = wdat[7:0];
            end else begin
                ref_mem[w] = wdat;
            end
        end
        cpu_q.push_back(e);
        bus.cpu_rd = rd; bus.cpu_wt = wr; bus.cpu_byte = bt;
        bus.cpu_adr = adr; bus.cpu_out = wdat;
        lat = 0; we_cnt = 0; doe_cnt = 0; oe_cnt = 0;
        a_seen = '0; ub_seen = 1'b1; lb_seen = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge m_clock);
            if (bus.cpu_rdy) begin
                lat = c;
                break;
            end
            if (!bus.sram_we_n) we_cnt++;
            if (bus.sram_d_oe)  doe_cnt++;
            if (!bus.sram_oe_n) oe_cnt++;
            if (!bus.sram_oe_n || bus.sram_d_oe) begin
                a_seen = bus.sram_a; ub_seen = bus.sram_ub_n; lb_seen = bus.sram_lb_n;
            end
        end
        hold_quiet = bus.sram_we_n & bus.sram_oe_n & bus.sram_ub_n & bus.sram_lb_n & ~bus.sram_d_oe;
        bus.cpu_rd = 1'b0; bus.cpu_wt = 1'b0; bus.cpu_byte = 1'b0;
        @(negedge m_clock);
        rdy_after = bus.cpu_rdy;
        if (lat > 0) stall_exp += lat - ACC_LAT;
    endtask

    typedef struct {
        logic          rd, wr, bt;
        logic [15:0]   adr, wdat;
        logic [AW-1:0] exp_a;
        logic          exp_ub_n, exp_lb_n;
    } vec_t;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[8];
        int lat, we_cnt, doe_cnt, oe_cnt, n_c, n_v, bad;
        logic [AW-1:0] a_seen;
        logic ub_seen, lb_seen, hold_quiet, rdy_after;
        logic [15:0] old_word;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'h1234, 14'h0080, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0101, 16'hABAB, 14'h0080, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 14'h0080, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0200, 16'h5A5A, 14'h0100, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 14'h0100, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h7FFE, 16'hBEEF, 14'h3FFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h7FFE, 16'h0000, 14'h3FFF, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, 14'h0080, 1'b0, 1'b0};

        for (int i = 0; i < (1<<AW); i++) begin
            sram[i]    = 16'(i) ^ 16'hC3C3;
            ref_mem[i] = 16'(i) ^ 16'hC3C3;
        end
        bus.cpu_rd = 1'b0; bus.cpu_wt = 1'b0; bus.cpu_byte = 1'b0;
        bus.cpu_adr = '0; bus.cpu_out = '0;
        bus.vid_req = 1'b0; bus.vid_adr = '0;
        vid_exp = '0;

        // Reset state
        p_reset = 1'b1;
        repeat (3) @(negedge m_clock);
        check("rst_cpu_rdy",  bus.cpu_rdy,   1'b0);
        check("rst_vid_ack",  bus.vid_ack,   1'b0);
        check("rst_we_n",     bus.sram_we_n, 1'b1);
        check("rst_oe_n",     bus.sram_oe_n, 1'b1);
        check("rst_ub_n",     bus.sram_ub_n, 1'b1);
        check("rst_lb_n",     bus.sram_lb_n, 1'b1);
        check("rst_d_oe",     bus.sram_d_oe, 1'b0);
        check("rst_sram_a",   bus.sram_a,    '0);
        check("rst_sram_d_o", bus.sram_d_o,  16'h0000);
        check("rst_cpu_in",   bus.cpu_in,    16'h0000);
        check("rst_vid_data", bus.vid_data,  16'h0000);
        p_reset = 1'b0;
        @(negedge m_clock);

        // Simultaneous video and CPU request right after reset: video first, then CPU
        bus.vid_adr = 14'h0123;
        vid_exp = ref_mem[14'h0123];
        bus.vid_req = 1'b1;
        cpu_q.push_back('{1'b1, ref_mem[14'h0080]});
        bus.cpu_rd = 1'b1; bus.cpu_adr = 16'h0100;
        n_v = 0; lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge m_clock);
            if (bus.vid_ack) n_v++;
            if (bus.cpu_rdy) begin
                lat = c;
                break;
            end
        end
        check("t3_vid_before_cpu", n_v, 1);
        check("t3_cpu_lat", lat, MAX_LAT);
        if (lat > 0) stall_exp += lat - ACC_LAT;
        bus.vid_req = 1'b0; bus.cpu_rd = 1'b0;
        @(negedge m_clock);
        check("t3_rdy_drop", bus.cpu_rdy, 1'b0);
        @(negedge m_clock);

        // Table of isolated CPU accesses
        for (int i = 0; i < 8; i++) begin
            cpu_access(vecs[i].rd, vecs[i].wr, vecs[i].bt, vecs[i].adr, vecs[i].wdat,
                       lat, we_cnt, doe_cnt, oe_cnt, a_seen, ub_seen, lb_seen, hold_quiet, rdy_after);
            check($sformatf("v%0d_lat", i),   lat, ACC_LAT);
            check($sformatf("v%0d_addr", i),  a_seen, vecs[i].exp_a);
            check($sformatf("v%0d_ub_n", i),  ub_seen, vecs[i].exp_ub_n);
            check($sformatf("v%0d_lb_n", i),  lb_seen, vecs[i].exp_lb_n);
            check($sformatf("v%0d_we", i),    we_cnt, vecs[i].wr ? WS : 0);
            check($sformatf("v%0d_doe", i),   doe_cnt, vecs[i].wr ? WS + 1 : 0);
            check($sformatf("v%0d_oe", i),    oe_cnt, vecs[i].wr ? 0 : WS + 1);
            check($sformatf("v%0d_hold", i),  hold_quiet, 1'b1);
            check($sformatf("v%0d_rdy_drop", i), rdy_after, 1'b0);
            if (i == 2) check("t2_word_read", bus.cpu_in, 16'hAB34);
        end

        // Video held continuously while the CPU issues 4 reads: strict alternation
        order.delete();
        bus.vid_adr = 14'h2AAA;
        vid_exp = ref_mem[14'h2AAA];
        bus.vid_req = 1'b1;
        @(negedge m_clock);
        for (int k = 0; k < 4; k++) begin
            cpu_access(1'b1, 1'b0, 1'b0, 16'h0400 + 16'(k * 2), 16'h0000,
                       lat, we_cnt, doe_cnt, oe_cnt, a_seen, ub_seen, lb_seen, hold_quiet, rdy_after);
            check($sformatf("t4_lat_ok_%0d", k), (lat > 0 && lat <= MAX_LAT), 1'b1);
            check($sformatf("t4_rdy_drop_%0d", k), rdy_after, 1'b0);
        end
        bus.vid_req = 1'b0;
        repeat (5) @(negedge m_clock);
        n_c = 0; n_v = 0; bad = 0;
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == 0) begin
                n_c++;
                if (i == 0 || order[i-1] == 0) bad++;
            end else begin
                n_v++;
            end
        end
        check("t4_cpu_count", n_c, 4);
        check("t4_no_back_to_back_cpu", bad, 0);
        check("t4_vid_served", (n_v >= 4), 1'b1);

`ifdef MEM_ARB_STATS_EN
        // Stall counter against the bench's tally, then saturation
        check("t6_stall_cnt", cpu_stall_cnt, stall_exp[15:0]);
        force dut.stall_cnt = 16'hFFFF;
        @(negedge m_clock);
        release dut.stall_cnt;
        bus.vid_req = 1'b1;
        @(negedge m_clock);
        cpu_access(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0000,
                   lat, we_cnt, doe_cnt, oe_cnt, a_seen, ub_seen, lb_seen, hold_quiet, rdy_after);
        check("t6_stalled", (lat > ACC_LAT), 1'b1);
        check("t6_saturated", cpu_stall_cnt, 16'hFFFF);
        bus.vid_req = 1'b0;
        repeat (5) @(negedge m_clock);
`endif

        // Reset in the middle of a write ACCESS
        old_word = ref_mem[14'h0300];
        ref_mem[14'h0300] = 16'h7777;
        cpu_q.push_back('{1'b0, 16'h0000});
        bus.cpu_wt = 1'b1; bus.cpu_byte = 1'b0; bus.cpu_adr = 16'h0600; bus.cpu_out = 16'h7777;
        @(negedge m_clock);
        check("t5_we_active", bus.sram_we_n, 1'b0);
        #2 p_reset = 1'b1;
        #1;
        check("t5_async_we_n", bus.sram_we_n, 1'b1);
        check("t5_async_d_oe", bus.sram_d_oe, 1'b0);
        check("t5_async_rdy",  bus.cpu_rdy,   1'b0);
        @(negedge m_clock);
        check("t5_no_write", sram[14'h0300], old_word);
        p_reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge m_clock);
            if (bus.cpu_rdy) begin
                lat = c;
                break;
            end
        end
        check("t5_reserved_lat", lat, ACC_LAT);
        check("t5_written", sram[14'h0300], 16'h7777);
        bus.cpu_wt = 1'b0;
        @(negedge m_clock);
        check("t5_rdy_drop", bus.cpu_rdy, 1'b0);
        @(negedge m_clock);
        check("scoreboard_empty", cpu_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bk_mem_arbiter.md
Name: bk_mem_arbiter

Overview:
- Sequences the single 16-bit external SRAM and shares it between the CPU bus port of the BK core and the video scan-out fetcher.
- Converts the core's level rd/wt/byte strobes into timed SRAM cycles with byte lanes, then returns cpu_rdy.
- Video gets priority for real-time scan-out; a fairness rule bounds how long the CPU can be stalled.

Parameters:
WAIT_STATES, 1, extra SRAM cycles per access; an access occupies WAIT_STATES+1 clocks in ACCESS.
ADDR_W, 14, SRAM word address width (32 KB RAM).

Ports:
m_clock  in  1  system clock
p_reset  in  1  asynchronous active-high reset
cpu_rd  in  1  CPU read request (level, RAM space only)
cpu_wt  in  1  CPU write request (level, RAM space only)
cpu_byte  in  1  byte access
cpu_adr  in  16  CPU byte address; bits [ADDR_W:1] select the word
cpu_out  in  16  CPU write data; byte data is already replicated on both lanes
cpu_in  out  16  read data to CPU, full word
cpu_rdy  out  1  access complete; held until cpu_rd and cpu_wt are both low
vid_req  in  1  video word fetch request (level)
vid_adr  in  ADDR_W  video word address
vid_ack  out  1  one-clock pulse: vid_data is valid
vid_data  out  16  fetched video word
sram_a  out  ADDR_W  SRAM word address
sram_d_i  in  16  SRAM read data
sram_d_o  out  16  SRAM write data
sram_d_oe  out  1  drive the SRAM data bus
sram_we_n  out  1  write enable, active low
sram_oe_n  out  1  output enable, active low
sram_ub_n  out  1  upper byte enable, active low
sram_lb_n  out  1  lower byte enable, active low

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - sram_we_n=sram_oe_n=sram_ub_n=sram_lb_n=1, sram_d_oe=0.
  - cpu_rdy=0, vid_ack=0.
  - cpu_in, vid_data, sram_a, sram_d_o = 0.
  - last_vid=0.
  - An access in flight is abandoned and no write completes.
- States: IDLE, ACCESS, CPU_HOLD.
- IDLE arbitration, evaluated each clock:
  - vid_req and CPU pending (cpu_rd|cpu_wt, cpu_rdy=0) together: grant CPU if last_vid=1, else video.
  - Only one pending: grant it.
  - cpu_rd and cpu_wt both high: treated as a write.
- Grant to ACCESS (next clock):
  - Latch sram_a, the direction, and lanes.
  - Video grant sets last_vid=1; CPU grant sets last_vid=0.
- Read: sram_oe_n=0 for the whole of ACCESS.
- Write:
  - sram_d_oe=1 and sram_d_o=cpu_out for the whole of ACCESS.
  - sram_we_n=0 on all ACCESS cycles except the last, so data is held one clock past the WE rising edge.
  - With WAIT_STATES=0, sram_we_n=0 for the single cycle and data holds 1 cycle into the next state.
- Lanes:
  - Word access: both lanes low.
  - Byte access: cpu_adr[0]=1 selects ub only; cpu_adr[0]=0 selects lb only.
  - Reads always enable both lanes.
- ACCESS length is WAIT_STATES+1 clocks. On the last clock:
  - Reads sample sram_d_i.
  - Video: vid_data<=sram_d_i and vid_ack pulses 1 clock; return to IDLE.
  - CPU: cpu_in<=sram_d_i (reads); cpu_rdy<=1; go to CPU_HOLD.
- CPU_HOLD:
  - SRAM strobes are inactive and cpu_rdy stays 1.
  - When cpu_rd=cpu_wt=0, clear cpu_rdy and go to IDLE.
  - Video requests are served only after this; the CPU drops its strobes within a few clocks.
- Latency:
  - Grant occurs 1 clock after the request is seen in IDLE.
  - cpu_rdy/vid_ack are registered, rising WAIT_STATES+1 clocks after the grant.
- Worst-case CPU wait is one video access plus its own access (alternation guarantee).
- A video request dropped before its grant is ignored; vid_req held across vid_ack starts a new fetch.

Optional Feature:
MEM_ARB_STATS_EN:
- Defined: adds output cpu_stall_cnt[15:0].
  - Increments each clock the CPU is pending in IDLE but video is granted, or the CPU is waiting while the state is ACCESS serving video.
  - Saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. WAIT_STATES=1; CPU word write 16'h1234 to adr 16'h0100:
   - sram_a=14'h080, ub_n=lb_n=0, we_n low 1 clock, d_oe 2 clocks.
   - cpu_rdy rises 3 clocks after cpu_wt and falls 1 clock after cpu_wt drops.
2. Byte write to adr 16'h0101 with cpu_out=16'hABAB:
   - only sram_ub_n=0.
   - A following word read of 16'h0100 returns 16'hAB34 on cpu_in.
3. vid_req and cpu_rd asserted in the same clock after reset (last_vid=0):
   - video served first with vid_ack and vid_data = SRAM word.
   - CPU served next; no second video grant before cpu_rdy.
4. vid_req held continuously while the CPU issues 4 reads:
   - grants alternate V,C,V,C…; every CPU read completes within 2×(WAIT_STATES+1)+2 clocks of request.
5. Assert p_reset during a write ACCESS:
   - sram_we_n=1 and sram_d_oe=0 immediately (same clock, asynchronous).
   - cpu_rdy=0; after release the state is IDLE and the pending CPU request is re-served.
6. MEM_ARB_STATS_EN defined, scenario 4 run:
   - cpu_stall_cnt equals the counted stalled clocks.
   - Forced to 16'hFFFF, it stays at 16'hFFFF on further stalls.
